// File: rtl/probe_rle_encoder_if.sv
// FX2 IN FIFO (FIFO4) byte port: write data/strobe toward the FIFO, ready back.
interface probe_rle_encoder_if;
  logic [7:0] fifo_data;
  logic       fifo_wr;
  logic       fifo_ready;

  modport master (
    output fifo_data,
    output fifo_wr,
    input  fifo_ready
  );

  modport slave (
    input  fifo_data,
    input  fifo_wr,
    output fifo_ready
  );
endinterface

// File: rtl/probe_rle_encoder.sv
// Run-length compressor for the logic analyzer capture path: emits (value, length-1) byte pairs.
// Optional raw pass-through mode is compiled in with `define PROBE_RLE_BYPASS_EN.
module probe_rle_encoder #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned MAX_RUN   = 256
) (
  input  logic                 FIFO_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           sample,
  input  logic                 clear_overflow,
`ifdef PROBE_RLE_BYPASS_EN
  input  logic                 bypass,
`endif
  probe_rle_encoder_if.master  fifo,
  output logic                 overflow,
  output logic                 activity
);

  localparam int unsigned        DEPTH      = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);
  localparam logic [7:0]         RUN_LAST   = 8'(MAX_RUN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VALUE,
    S_COUNT
  } state_t;

  logic                 r_run_valid;
  logic [7:0]           r_run_val;
  logic [7:0]           r_run_cnt;

  logic [15:0]          r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic [ADDR_BITS:0]   w_count_nxt;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 w_hold;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_drop;
  logic                 w_ovf_set;
  logic [15:0]          w_head;

`ifdef PROBE_RLE_BYPASS_EN
  assign w_hold = bypass;
`else
  assign w_hold = 1'b0;
`endif

  // A run closes on a value change, on reaching MAX_RUN, or when capture is disabled.
  always_comb begin
    w_push = 1'b0;
    if (!w_hold && r_run_valid) begin
      if (!enable)
        w_push = 1'b1;
      else if ((sample != r_run_val) || (r_run_cnt == RUN_LAST))
        w_push = 1'b1;
    end
  end

  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      r_run_valid <= 1'b0;
      r_run_val   <= '0;
      r_run_cnt   <= '0;
    end else if (w_hold) begin
      r_run_valid <= 1'b0;
      r_run_val   <= '0;
      r_run_cnt   <= '0;
    end else if (enable) begin
      if (r_run_valid && (sample == r_run_val) && (r_run_cnt != RUN_LAST)) begin
        r_run_cnt <= r_run_cnt + 8'd1;
      end else begin
        r_run_valid <= 1'b1;
        r_run_val   <= sample;
        r_run_cnt   <= '0;
      end
    end else begin
      r_run_valid <= 1'b0;
    end
  end

  assign w_full   = (r_count == FULL_COUNT);
  assign w_pop    = (r_state == S_COUNT) && fifo.fifo_ready && !w_hold;
  // When full, a same-cycle pop frees the head slot, so the push can take it.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;
  assign w_head   = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_accept, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge FIFO_clk) begin
    if (w_accept)
      r_mem[r_wr_ptr] <= {r_run_val, r_run_cnt};
  end

  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_hold) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

`ifdef PROBE_RLE_BYPASS_EN
  assign w_ovf_set = w_drop || (w_hold && enable && !fifo.fifo_ready);
`else
  assign w_ovf_set = w_drop;
`endif

  // Set has priority over clear so a drop is never hidden by a concurrent clear.
  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      activity <= 1'b0;
    end else begin
      if (w_ovf_set)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
      activity <= w_accept;
    end
  end

  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    fifo.fifo_data = '0;
    fifo.fifo_wr   = 1'b0;
    if (w_hold) begin
      w_state_nxt    = S_IDLE;
      fifo.fifo_data = sample;
      fifo.fifo_wr   = enable && fifo.fifo_ready;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_count != '0)
            w_state_nxt = S_VALUE;
        end
        S_VALUE: begin
          fifo.fifo_data = w_head[15:8];
          fifo.fifo_wr   = fifo.fifo_ready;
          if (fifo.fifo_ready)
            w_state_nxt = S_COUNT;
        end
        S_COUNT: begin
          fifo.fifo_data = w_head[7:0];
          fifo.fifo_wr   = fifo.fifo_ready;
          if (fifo.fifo_ready)
            w_state_nxt = (w_count_nxt != '0) ? S_VALUE : S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_probe_rle_encoder.sv
// Directed self-checking bench for probe_rle_encoder; captures the FIFO byte stream at negedge.
module tb_probe_rle_encoder;
  logic       FIFO_clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       clear_overflow = 1'b0;
  logic       overflow;
  logic       activity;
`ifdef PROBE_RLE_BYPASS_EN
  logic       bypass = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int act_cnt  = 0;
  logic [7:0] captured[$];
  logic [7:0] exp_q[$];

  probe_rle_encoder_if bus ();

  probe_rle_encoder #(
    .ADDR_BITS(4),
    .MAX_RUN(256)
  ) dut (
    .FIFO_clk      (FIFO_clk),
    .reset         (reset),
    .enable        (enable),
    .sample        (sample),
    .clear_overflow(clear_overflow),
`ifdef PROBE_RLE_BYPASS_EN
    .bypass        (bypass),
`endif
    .fifo          (bus.master),
    .overflow      (overflow),
    .activity      (activity)
  );

  always #5 FIFO_clk = ~FIFO_clk;

  always @(negedge FIFO_clk) begin
    if (bus.fifo_wr === 1'b1)
      captured.push_back(bus.fifo_data);
    if (activity === 1'b1)
      act_cnt++;
  end

  task automatic run_cycles(input int n);
    repeat (n) @(posedge FIFO_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    sample = 8'h00;
    clear_overflow = 1'b0;
    bus.fifo_ready = 1'b1;
    repeat (2) @(posedge FIFO_clk);
    #1;
    reset = 1'b0;
    captured.delete();
    act_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fifo_ready = 1'b1;
    #2;
    n_checks++;
    if (bus.fifo_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b expected 0", bus.fifo_wr); end
    n_checks++;
    if (bus.fifo_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.fifo_data); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_checks++;
    if (activity !== 1'b0) begin n_fail++; $display("FAIL reset_act: got %b expected 0", activity); end
    do_reset();
    run_cycles(4);
    n_checks++;
    if (captured.size() != 0) begin n_fail++; $display("FAIL reset_idle: got %0d bytes expected 0", captured.size()); end
  endtask

  task automatic test_single_run();
    do_reset();
    enable = 1'b1;
    sample = 8'hA5;
    run_cycles(10);
    enable = 1'b0;
    run_cycles(10);
    exp_q = '{8'hA5, 8'h09};
    n_checks++;
    if (captured.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len: got %0d expected %0d", captured.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= captured.size() || captured[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_byte%0d: got %h expected %h", i, (i < captured.size()) ? captured[i] : 8'hxx, exp_q[i]);
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b expected 0", overflow); end
    n_checks++;
    if (act_cnt != 1) begin n_fail++; $display("FAIL single_act: got %0d pulses expected 1", act_cnt); end
  endtask

  task automatic test_max_run();
    do_reset();
    enable = 1'b1;
    sample = 8'h01;
    run_cycles(300);
    enable = 1'b0;
    run_cycles(10);
    exp_q = '{8'h01, 8'hFF, 8'h01, 8'h2B};
    n_checks++;
    if (captured.size() != exp_q.size()) begin n_fail++; $display("FAIL maxrun_len: got %0d expected %0d", captured.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= captured.size() || captured[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL maxrun_byte%0d: got %h expected %h", i, (i < captured.size()) ? captured[i] : 8'hxx, exp_q[i]);
      end
    end
    n_checks++;
    if (act_cnt != 2) begin n_fail++; $display("FAIL maxrun_act: got %0d pulses expected 2", act_cnt); end
  endtask

  task automatic test_toggle_overflow();
    int bad_pairs;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sample = (i % 2 == 0) ? 8'h00 : 8'h01;
      run_cycles(1);
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL toggle_ovf: got %b expected 1", overflow); end
    enable = 1'b0;
    run_cycles(60);
    n_checks++;
    if (captured.size() % 2 != 0) begin n_fail++; $display("FAIL toggle_whole_pairs: got %0d bytes expected even", captured.size()); end
    n_checks++;
    if (captured.size() < 34) begin n_fail++; $display("FAIL toggle_volume: got %0d bytes expected >= 34", captured.size()); end
    n_checks++;
    if (captured.size() == 0 || captured[0] !== 8'h00) begin n_fail++; $display("FAIL toggle_first: got %h expected 00", (captured.size() > 0) ? captured[0] : 8'hxx); end
    bad_pairs = 0;
    for (int i = 0; i + 1 < captured.size(); i += 2) begin
      if (captured[i+1] !== 8'h00 || (captured[i] !== 8'h00 && captured[i] !== 8'h01))
        bad_pairs++;
    end
    n_checks++;
    if (bad_pairs != 0) begin n_fail++; $display("FAIL toggle_pairs: got %0d malformed pairs expected 0", bad_pairs); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.fifo_ready = 1'b0;
    enable = 1'b1;
    sample = 8'h3C;
    run_cycles(5);
    sample = 8'hC3;
    run_cycles(3);
    enable = 1'b0;
    run_cycles(3);
    @(negedge FIFO_clk);
    n_checks++;
    if (bus.fifo_wr !== 1'b0 || bus.fifo_data !== 8'h3C) begin
      n_fail++; $display("FAIL stall_value_hold: got wr=%b data=%h expected wr=0 data=3c", bus.fifo_wr, bus.fifo_data);
    end
    @(posedge FIFO_clk);
    #1;
    bus.fifo_ready = 1'b1;
    run_cycles(1);
    bus.fifo_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge FIFO_clk);
      n_checks++;
      if (bus.fifo_wr !== 1'b0 || bus.fifo_data !== 8'h04) begin
        n_fail++; $display("FAIL stall_count_hold%0d: got wr=%b data=%h expected wr=0 data=04", c, bus.fifo_wr, bus.fifo_data);
      end
      @(posedge FIFO_clk);
      #1;
    end
    bus.fifo_ready = 1'b1;
    run_cycles(10);
    exp_q = '{8'h3C, 8'h04, 8'hC3, 8'h02};
    n_checks++;
    if (captured.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_len: got %0d expected %0d", captured.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= captured.size() || captured[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", i, (i < captured.size()) ? captured[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_clear_overflow();
    do_reset();
    bus.fifo_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample = (i % 2 == 0) ? 8'h10 : 8'h20;
      run_cycles(1);
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set: got %b expected 1", overflow); end
    enable = 1'b0;
    run_cycles(1);
    clear_overflow = 1'b1;
    run_cycles(1);
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_clear: got %b expected 0", overflow); end
    enable = 1'b1;
    sample = 8'h00;
    run_cycles(1);
    sample = 8'h01;
    clear_overflow = 1'b1;
    run_cycles(1);
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins: got %b expected 1", overflow); end
    n_checks++;
    if (activity !== 1'b0) begin n_fail++; $display("FAIL clr_drop_no_act: got %b expected 0", activity); end
    enable = 1'b0;
    run_cycles(2);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.fifo_ready = 1'b0;
    enable = 1'b1;
    sample = 8'h55;
    run_cycles(2);
    sample = 8'h66;
    run_cycles(1);
    enable = 1'b0;
    run_cycles(3);
    bus.fifo_ready = 1'b1;
    run_cycles(1);
    bus.fifo_ready = 1'b0;
    @(negedge FIFO_clk);
    n_checks++;
    if (bus.fifo_wr !== 1'b0 || bus.fifo_data !== 8'h01) begin
      n_fail++; $display("FAIL rst_in_count: got wr=%b data=%h expected wr=0 data=01", bus.fifo_wr, bus.fifo_data);
    end
    @(posedge FIFO_clk);
    #1;
    bus.fifo_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.fifo_wr !== 1'b0) begin n_fail++; $display("FAIL rst_async_wr: got %b expected 0", bus.fifo_wr); end
    @(posedge FIFO_clk);
    #1;
    reset = 1'b0;
    captured.delete();
    run_cycles(5);
    n_checks++;
    if (captured.size() != 0) begin n_fail++; $display("FAIL rst_queue_empty: got %0d bytes expected 0", captured.size()); end
    enable = 1'b1;
    sample = 8'h7E;
    run_cycles(3);
    enable = 1'b0;
    run_cycles(8);
    exp_q = '{8'h7E, 8'h02};
    n_checks++;
    if (captured.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_len: got %0d expected %0d", captured.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= captured.size() || captured[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rst_byte%0d: got %h expected %h", i, (i < captured.size()) ? captured[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.fifo_ready = 1'b1;
    test_reset();
    test_single_run();
    test_max_run();
    test_toggle_overflow();
    test_stall();
    test_clear_overflow();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/probe_rle_encoder.md
Name: probe_rle_encoder

Overview:
Run-length compressor for the built-in logic analyzer capture path. It takes the 2-stage-synchronized 8-bit probe sample on every FIFO_clk and emits (value, run length) byte pairs into the FX2 IN FIFO (FIFO4). Captures of slow PSX bus activity therefore no longer saturate USB bandwidth. It sits between the probe synchronizer and the FIFO_DATAOUT/FIFO_WR pins.

Parameters:
ADDR_BITS, 4, log2 of token queue depth (DEPTH = 2^ADDR_BITS entries, 16 bits each)
MAX_RUN, 256, maximum run length per token; legal range 2..256

Ports:
FIFO_clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  capture enable; a falling edge flushes the open run
sample  input  8  synchronized probe sample, valid every cycle
fifo_ready  input  1  FIFO4_ready_to_accept_data
clear_overflow  input  1  synchronous clear of the overflow flag
fifo_data  output  8  byte to FIFO_DATAOUT
fifo_wr  output  1  FIFO write strobe; one byte transferred per cycle while high
overflow  output  1  sticky flag: at least one token was dropped
activity  output  1  one-cycle pulse on each accepted token push

Behaviour:
- Reset (asynchronous, active-high; clock FIFO_clk): run_valid=0, run_val=0, run_cnt=0, queue empty, serializer IDLE, overflow=0, activity=0. fifo_wr=0 and fifo_data=0 while in IDLE.
- Run accumulator: run_cnt holds run length minus 1 (8 bits). At each edge with enable=1:
  - If !run_valid: load run_val=sample, run_cnt=0, run_valid=1.
  - Else if sample==run_val and run_cnt!=MAX_RUN-1: run_cnt+1.
  - Else: push token {run_val, run_cnt}, then load run_val=sample, run_cnt=0.
- Enable low: at each edge with enable=0 and run_valid=1, push the open run and clear run_valid. No pushes occur while disabled after that.
- Token queue: circular, DEPTH entries, count ADDR_BITS+1 bits wide.
  - A push while full is dropped and sets overflow; activity does not pulse.
  - A push and a pop in the same cycle while full: the push is accepted and count is unchanged.
  - overflow stays set until reset or clear_overflow. If clear_overflow and a drop occur in the same cycle, the set wins.
- Serializer FSM with states IDLE, VALUE, COUNT:
  - IDLE -> VALUE at the edge where the queue is non-empty.
  - VALUE: fifo_data=head.value, fifo_wr=fifo_ready. On fifo_ready -> COUNT.
  - COUNT: fifo_data=head.count, fifo_wr=fifo_ready. On fifo_ready: pop; go to VALUE if entries remain after the pop, else IDLE.
  - fifo_ready low holds the state and fifo_data stable. fifo_wr is combinational from state and fifo_ready.
- Latency: a token pushed at edge N drives its value byte during cycle N+1..N+2 (after the IDLE->VALUE edge). The count byte follows on the next ready cycle.
- The byte stream is always whole pairs. Drops remove complete tokens only.
- Throughput: 1 byte per cycle maximum. A sample change every cycle produces 2 bytes per cycle, so the queue fills and overflow is expected in that case.

Optional Feature:
PROBE_RLE_BYPASS_EN
- Defined: adds input port bypass (1 bit). While bypass=1, fifo_data=sample and fifo_wr=enable&fifo_ready, passed raw every cycle. The accumulator and queue are held in reset-equivalent state and overflow is set when enable=1 and fifo_ready=0.
- Undefined: no bypass port; RLE only.

Test Plan:
1. fifo_ready=1, sample=8'hA5 with enable=1 for 10 cycles, then enable=0 -> exactly bytes A5, 09; overflow=0; one activity pulse.
2. MAX_RUN=256, sample=8'h01 for 300 enabled cycles, then disable -> bytes 01 FF 01 2B.
3. ADDR_BITS=4, fifo_ready=1, sample toggling 00/01 every cycle for 64 cycles -> overflow asserts once the queue holds 16 tokens; the output is alternating well-formed pairs (x, 00) with no half token.
4. Run of 8'h3C (len 5) followed by 8'hC3 (len 3) with fifo_ready dropped for 4 cycles while in COUNT -> fifo_wr=0 and fifo_data held at 04 during the stall; final stream 3C 04 C3 02; no byte lost or duplicated.
5. Overflow set, then pulse clear_overflow -> overflow=0 next cycle. Repeat with a drop in the same cycle -> overflow remains 1.
6. Assert reset mid-stream with the serializer in COUNT -> fifo_wr=0 immediately and the queue empty. After release with a constant 8'h7E for 3 cycles and then disable -> stream 7E 02 only.
